// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between two requesters.
// Each access takes one ISSUE cycle on the memory bus, then a one-cycle ack to the winner.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [DATA_WIDTH-1:0] memReadData,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   winner;

    logic   grant_valid;
    logic   grant_port;
    logic   grant_we;

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else if (req1) begin
            grant_port = 1'b1;
        end
        grant_we = grant_port ? we1 : we0;
    end

    // NOTE: state and registered outputs use non-blocking assignments so every
    // read in this block sees the value from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            winner       <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            busy         <= 1'b0;
            memWrite     <= 1'b0;
            memRead      <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        // The memory-side registers double as the latched request.
                        winner       <= grant_port;
                        memAddress   <= grant_port ? addr1 : addr0;
                        memWriteData <= grant_port ? wdata1 : wdata0;
                        memWrite     <= grant_we;
                        memRead      <= ~grant_we;
                        busy         <= 1'b1;
                        state        <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (memRead) begin
                        if (winner) begin
                            rdata1 <= memReadData;
                        end else begin
                            rdata0 <= memReadData;
                        end
                    end
                    memWrite <= 1'b0;
                    memRead  <= 1'b0;
                    ack0     <= ~winner;
                    ack1     <= winner;
                    state    <= DONE;
                end

                DONE: begin
                    last_grant <= winner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    busy     <= 1'b0;
                    memWrite <= 1'b0;
                    memRead  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    a_ack_exclusive: assert property (@(posedge clock) disable iff (reset) !(ack0 && ack1));
    a_mem_exclusive: assert property (@(posedge clock) disable iff (reset) !(memWrite && memRead));
    a_busy_tracks:   assert property (@(posedge clock) disable iff (reset) busy == (state != IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small word memory stands in for dataMemory and
// per-port queues hold the rdata expected at each ack.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock;
    logic          reset;
    logic          req0, we0, ack0;
    logic          req1, we1, ack1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memWriteData, memReadData;
    logic          memWrite, memRead;
    logic          busy;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req0         (req0),
        .we0          (we0),
        .addr0        (addr0),
        .wdata0       (wdata0),
        .ack0         (ack0),
        .rdata0       (rdata0),
        .req1         (req1),
        .we1          (we1),
        .addr1        (addr1),
        .wdata1       (wdata1),
        .ack1         (ack1),
        .rdata1       (rdata1),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .memReadData  (memReadData),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Stand-in for dataMemory: write on the edge closing ISSUE, combinational read.
    logic [DW-1:0] mem [0:15];
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge clock) if (memWrite) mem[memAddress[3:0]] <= memWriteData;
    assign memReadData = memRead ? mem[memAddress[3:0]] : '0;

    int            errors = 0;
    int            checks = 0;
    int            cycle  = 0;
    int            wr_cycles = 0;
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] rd0_model = '0;
    logic [DW-1:0] rd1_model = '0;
    int            ack_port[$];
    int            ack_cycle[$];
    bit            hold0 = 1'b0;
    bit            hold1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any acks seen there.
    task automatic step();
        logic [DW-1:0] exp;
        @(negedge clock);
        cycle++;
        check("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        check("mem_exclusive", 32'(memWrite & memRead), 32'd0);
        if (memWrite) wr_cycles++;
        if (ack0) begin
            ack_port.push_back(0);
            ack_cycle.push_back(cycle);
            if (q0.size() == 0) begin
                check("ack0_unexpected", 32'd1, 32'd0);
            end else begin
                exp = q0.pop_front();
                check("rdata0_at_ack", rdata0, exp);
                if (hold0) q0.push_back(exp);
                else req0 = 1'b0;
            end
        end
        if (ack1) begin
            ack_port.push_back(1);
            ack_cycle.push_back(cycle);
            if (q1.size() == 0) begin
                check("ack1_unexpected", 32'd1, 32'd0);
            end else begin
                exp = q1.pop_front();
                check("rdata1_at_ack", rdata1, exp);
                if (hold1) q1.push_back(exp);
                else req1 = 1'b0;
            end
        end
    endtask

    // rd is the rdata expected at ack for a read; a write leaves the port's rdata as it was.
    task automatic issue(input bit port, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [DW-1:0] rd);
        if (!port) begin
            if (!w) rd0_model = rd;
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
            q0.push_back(rd0_model);
        end else begin
            if (!w) rd1_model = rd;
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
            q1.push_back(rd1_model);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    task automatic do_reset();
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        rd0_model = '0;
        rd1_model = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset state
        do_reset();
        check("reset_ctrl", 32'({ack0, ack1, busy, memWrite, memRead}), 32'd0);
        check("reset_memAddress", memAddress, 32'd0);
        check("reset_memWriteData", memWriteData, 32'd0);
        check("reset_rdata0", rdata0, 32'd0);
        check("reset_rdata1", rdata1, 32'd0);

        // Single write then read
        wr_cycles = 0;
        issue(1'b0, 1'b1, 32'd7, 32'hE000_0000, 32'h0);
        step();
        check("t1_issue_ctrl", 32'({busy, memWrite, memRead, ack0}), 32'b1100);
        check("t1_issue_addr", memAddress, 32'd7);
        check("t1_issue_wdata", memWriteData, 32'hE000_0000);
        step();
        check("t1_ack0_latency", 32'({ack0, memWrite, busy}), 32'b101);
        step();
        check("t1_back_idle", 32'({ack0, busy}), 32'd0);
        check("t1_write_cycles", 32'(wr_cycles), 32'd1);
        issue(1'b1, 1'b0, 32'd7, 32'h0000_1111, 32'hE000_0000);
        wait_idle(10);
        check("t1_rdata0_untouched", rdata0, 32'd0);

        // Simultaneous requests after reset: port 0 wins the first tie
        do_reset();
        ack_port.delete();
        ack_cycle.delete();
        issue(1'b0, 1'b1, 32'd6, 32'hFFFF_FFFF, 32'h0);
        issue(1'b1, 1'b0, 32'd6, 32'h0, 32'hFFFF_FFFF);
        wait_idle(20);
        check("t2_ack_count", 32'(ack_port.size()), 32'd2);
        if (ack_port.size() == 2) begin
            check("t2_first_port", 32'(ack_port[0]), 32'd0);
            check("t2_second_port", 32'(ack_port[1]), 32'd1);
            check("t2_ack_spacing", 32'(ack_cycle[1] - ack_cycle[0]), 32'd3);
        end

        // Fairness under continuous requests
        ack_port.delete();
        ack_cycle.delete();
        hold0 = 1'b1;
        hold1 = 1'b1;
        issue(1'b0, 1'b1, 32'd8, 32'hAAAA_AAAA, 32'h0);
        issue(1'b1, 1'b0, 32'd8, 32'h0, 32'hAAAA_AAAA);
        repeat (12) step();
        hold0 = 1'b0;
        hold1 = 1'b0;
        wait_idle(20);
        check("t3_enough_acks", 32'(ack_port.size() >= 4), 32'd1);
        if (ack_port.size() > 0) check("t3_first_port", 32'(ack_port[0]), 32'd0);
        for (int i = 1; i < ack_port.size(); i++) begin
            check("t3_alternate", 32'(ack_port[i]), 32'(1 - ack_port[i-1]));
            check("t3_spacing", 32'(ack_cycle[i] - ack_cycle[i-1]), 32'd3);
        end

        // Reset during ISSUE: no ack, then the held request is served again
        issue(1'b0, 1'b1, 32'd9, 32'h1234_5678, 32'h0);
        step();
        step();
        check("t4_in_issue", 32'({busy, memWrite}), 32'b11);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd0_model = '0;
        rd1_model = '0;
        check("t4_after_reset", 32'({ack0, busy, memWrite}), 32'd0);
        wait_idle(10);
        issue(1'b1, 1'b0, 32'd9, 32'h0000_BEEF, 32'h1234_5678);
        wait_idle(10);

        // Idle hygiene; memory-side address/data hold their last values
        step();
        for (int i = 0; i < 10; i++) begin
            check("t5_idle_ctrl", 32'({ack0, ack1, busy, memWrite, memRead}), 32'd0);
            step();
        end
        check("t5_addr_held", memAddress, 32'd9);
        check("t5_wdata_held", memWriteData, 32'h0000_BEEF);

        // Read isolation
        issue(1'b1, 1'b0, 32'd3, 32'h0, 32'h0);
        wait_idle(10);
        issue(1'b0, 1'b1, 32'd3, 32'h55AA_55AA, 32'h0);
        wait_idle(10);
        check("t6_rdata1_after_write", rdata1, 32'd0);
        check("t6_rdata0_after_write", rdata0, 32'd0);
        issue(1'b0, 1'b0, 32'd3, 32'h0, 32'h55AA_55AA);
        wait_idle(10);
        check("t6_rdata1_loser", rdata1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
